// File: rtl/sequence_pkg.sv
// rtl/sequence_pkg.sv - shared types and width helpers for the sequence output collector
// Contents: state_t (FILL/COLLECT), CNT_W (frame counter width),
//           clog2_min1() used for IDX_W = clog2(N) and the skip counter width.
package sequence_pkg;

  typedef enum logic {
    FILL    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam int CNT_W = 16;

  // Ceiling log2 that never returns less than 1, so a register sized with it
  // always has at least one bit.
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sequence_order_check.sv
// rtl/sequence_order_check.sv - running monotonic-order check across the words of one frame
// Ports: clk, rst (async, active-high); en = collecting this cycle;
//        first = current word is slot 0 of a frame; inp = current word;
//        err_next = accumulated ordering error including the current word.
module sequence_order_check #(
  parameter int DW     = 8,
  parameter int ASCEND = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          first,
  input  logic [DW-1:0] inp,
  output logic          err_next
);

  logic [DW-1:0] prev;
  logic          err_acc;
  logic          viol;

  always_comb begin
    viol     = (ASCEND != 0) ? (inp < prev) : (inp > prev);
    // Slot 0 has no predecessor in this frame, so it restarts the accumulator.
    err_next = first ? 1'b0 : (err_acc | viol);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= '0;
      err_acc <= 1'b0;
    end else if (en) begin
      prev    <= inp;
      err_acc <= err_next;
    end
  end

endmodule

// File: rtl/sequence_output_collector.sv
// rtl/sequence_output_collector.sv - skips sorter fill words, packs N-word frames, flags misordered frames
// Ports: clk, rst (async, active-high); inp = serial word stream, one per cycle;
//        frame = last completed frame (word 0 in the LSBs); frame_valid = one-cycle
//        pulse on update; order_err = ordering violation, valid with frame_valid;
//        frame_cnt = completed frames since reset (wrapping).
module sequence_output_collector
  import sequence_pkg::*;
#(
  parameter int DW     = 8,
  parameter int N      = 4,
  parameter int SKIP   = 4,
  parameter int ASCEND = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     inp,
  output logic [N*DW-1:0]   frame,
  output logic              frame_valid,
  output logic              order_err,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int IDX_W  = clog2_min1(N);
  localparam int SKIP_W = clog2_min1(SKIP + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N - 1);
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? (SKIP - 1) : 0);
  // With no fill to skip, reset lands directly in COLLECT.
  localparam state_t RST_STATE = (SKIP == 0) ? COLLECT : FILL;

  state_t              state;
  logic [SKIP_W-1:0]   skip_cnt;
  logic [IDX_W-1:0]    idx;
  logic [N*DW-1:0]     shadow;
  logic [N*DW-1:0]     shadow_next;
  logic                collect;
  logic                first;
  logic                last;
  logic                err_next;

  always_comb begin
    collect     = (state == COLLECT);
    first       = (idx == '0);
    last        = (idx == IDX_LAST);
    // The completed frame must include the word arriving on the completing edge.
    shadow_next = shadow;
    shadow_next[DW*int'(idx) +: DW] = inp;
  end

  sequence_order_check #(
    .DW     (DW),
    .ASCEND (ASCEND)
  ) u_order_check (
    .clk      (clk),
    .rst      (rst),
    .en       (collect),
    .first    (first),
    .inp      (inp),
    .err_next (err_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RST_STATE;
      skip_cnt    <= '0;
      idx         <= '0;
      shadow      <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      order_err   <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_valid <= 1'b0;
      case (state)
        FILL: begin
          skip_cnt <= skip_cnt + SKIP_W'(1);
          if (skip_cnt == SKIP_LAST) begin
            state <= COLLECT;
          end
        end
        COLLECT: begin
          shadow <= shadow_next;
          // N is a power of two, so the natural wrap gives modulo-N indexing.
          idx    <= idx + IDX_W'(1);
          if (last) begin
            frame       <= shadow_next;
            order_err   <= err_next;
            frame_valid <= 1'b1;
            frame_cnt   <= frame_cnt + CNT_W'(1);
          end
        end
        default: state <= RST_STATE;
      endcase
    end
  end

endmodule

// File: doc/sequence_output_collector.md
# sequence_output_collector

Receive-side companion to the 4-word sequence sorter. It samples the sorter's free-running serial output stream and discards the pipeline-fill words after reset. It then reassembles every N consecutive words into one parallel frame and checks that each frame is monotonically ordered. It sits directly on the sorter's `outp` and hands complete, checked frames to downstream logic or to a scoreboard.

## Interface
- `DW`, 8, data word width in bits
- `N`, 4, words per frame; power of two, ≥2; matches the sorter depth
- `SKIP`, 4, cycles ignored after reset release (sorter pipeline fill); 0 allowed
- `ASCEND`, 1, 1 = require non-decreasing order, 0 = require non-increasing order
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `inp`  in  DW  serial word stream from the sorter output; one word per cycle, no valid qualifier
- `frame`  out  N*DW  last completed frame; word 0 (first received) in bits [DW-1:0]
- `frame_valid`  out  1  one-cycle pulse; `frame` was updated on this edge
- `order_err`  out  1  qualified by `frame_valid`; 1 if the frame violates the `ASCEND` ordering
- `frame_cnt`  out  16  completed frames since reset; wraps 0xFFFF→0

## Operation
- Reset (async assert) clears all outputs: `frame`=0, `frame_valid`=0, `order_err`=0, `frame_cnt`=0.
- Reset also forces state FILL with skip counter 0 and word index 0, and clears the partial frame and the error accumulator.
- FILL: `inp` is ignored. The skip counter increments each cycle. When it reaches SKIP-1, the state moves to COLLECT.
  - SKIP=0: reset goes straight to COLLECT.
- COLLECT: each cycle, `inp` is written to slot `idx` of the shadow frame and `idx` increments modulo N.
- Ordering check, for `idx`>0:
  - `err_acc` |= (ASCEND ? inp < prev : inp > prev), unsigned compare.
  - `prev` ← `inp` every COLLECT cycle.
  - Equal neighbours are legal.
  - `err_acc` is cleared at `idx`=0.
- Frame completion, when `idx`=N-1:
  - `frame` ← shadow frame including the current `inp`.
  - `order_err` ← final `err_acc` including the current compare.
  - `frame_valid` ← 1.
  - `frame_cnt` ← `frame_cnt`+1.
  - COLLECT continues with `idx`=0 on the next word. There is no gap between frames.
- No backpressure. The stream is free-running like the sorter; the collector never stalls or drops words once in COLLECT.
- `frame` and `order_err` hold their values between pulses. `order_err` is meaningful only while `frame_valid`=1.

## Timing
- Edge 0 is the first rising edge with `rst` low.
- Edges 0..SKIP-1 are FILL. Words are sampled on edges SKIP..SKIP+N-1.
- `frame_valid` is high from edge SKIP+N-1 until edge SKIP+N, a registered one-cycle pulse.
- Latency: 1 cycle from the last word of a frame to `frame_valid`/`frame`.
- Steady state: `frame_valid` pulses exactly every N cycles.
- Reset mid-FILL or mid-frame: the partial frame is discarded with no pulse. After release, the full SKIP fill is repeated and frame alignment restarts.
- Reset asserted in the same cycle as frame completion: reset wins and no pulse occurs.
- Counter wrap: a frame completing at `frame_cnt`=0xFFFF produces `frame_cnt`=0 with a normal pulse.

## Structure
- Shared package (`sequence_pkg`):
  - state enum {FILL, COLLECT}
  - `CNT_W` = 16 for `frame_cnt`
  - helper `IDX_W` = clog2(N)
- Skip counter width: clog2(SKIP+1), minimum 1.
- One sub-module is natural: `sequence_order_check`, holding `prev`, the direction compare and the `err_acc` accumulate/clear, parameterised by DW and ASCEND.
- Frame shadow register, index, FSM and counter stay in the top module.

## Test plan
All scenarios use DW=8, N=4, SKIP=4, ASCEND=1 unless noted.
- Release reset; drive 0xAA ×4, then 1,2,3,4 → one pulse after the 4th word; `frame`=0x04030201, `order_err`=0, `frame_cnt`=1. The 0xAA words never appear in `frame`.
- Back-to-back frames 5,3,7,9 then 7,7,7,7 → pulses exactly 4 cycles apart.
  - First frame: `frame`=0x09070305, `order_err`=1.
  - Second frame: `frame`=0x07070707, `order_err`=0.
  - `frame_cnt` goes 1→2.
- ASCEND=0, frame 9,7,7,1 → `order_err`=0; frame 1,9,7,7 → `order_err`=1.
- Assert `rst` after 2 words of a frame → no pulse and all outputs 0. After release, 4 skip cycles, then 10,20,30,40 → `frame`=0x281E140A, `frame_cnt`=1.
- SKIP=0, drive 1,2,3,4 from edge 0 → pulse after edge 3.
- Preload or run to `frame_cnt`=0xFFFF, then one more frame → `frame_cnt`=0 with `frame_valid`=1.
